mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between two requesters: the instruction-fetch stage (read-only) and the MEM-stage data access (read/write with byte enables).
- Sits between the pipeline and the memory interface.
- Sequences each access with a req/ready handshake, tolerates wait states, and reports per-requester completion and stall.
- DM has priority, with a starvation guard for IF and a per-access timeout.

Parameters:
- AW, 32, address width (word address).
- DW, 32, data width.
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF waits; 1..15.
- TIMEOUT, 255, cycles in BUSY without mem_ready before bus error; 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  AW  fetch word address.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  DW  fetched word, valid when if_ack=1.
- dm_req  in  1  data request; held with fields until dm_ack.
- dm_we  in  1  1=write, 0=read.
- dm_wea  in  4  byte enables (writes).
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  write data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  DW  read data, valid when dm_ack=1.
- bus_err  out  1  pulses together with the ack of a timed-out access.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_dm  out  1  dm_req & ~dm_ack (combinational).
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_wea  out  4  memory byte enables; 0 on reads.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- mem_ready  in  1  memory completion; may be high in the first BUSY cycle (zero wait).

Behaviour:
- The clock port is clk. Reset port rst is synchronous, active-high, single clock domain.
- Reset values:
  - state=IDLE, streak=0, timer=0.
  - if_ack, dm_ack, bus_err = 0.
  - if_rdata, dm_rdata = 0.
  - mem_req, mem_we = 0; mem_wea, mem_addr, mem_wdata = 0.
- States: IDLE, BUSY_IF, BUSY_DM.
- In IDLE, arbitrate over eligible requests. A requester is ineligible in the cycle its ack is high (mask), so a held req is not regranted.
  - Both eligible and streak<MAX_DM_STREAK: grant DM.
  - Both eligible and streak==MAX_DM_STREAK: grant IF.
  - Only one eligible: grant it.
- Grant is registered. On the next edge:
  - state=BUSY_x, mem_req=1, mem_* fields latched from requester x, timer=0.
  - For IF grants, mem_we=0 and mem_wea=0.
- In BUSY_x with mem_ready=1, on the edge:
  - x_ack=1 and x_rdata=mem_rdata, registered, valid the following cycle for exactly one cycle.
  - mem_req=0, state=IDLE.
  - For writes, x_rdata is 0.
- In BUSY_x with mem_ready=0: timer++. When timer reaches TIMEOUT-1 and mem_ready is still 0, on the edge:
  - x_ack=1, bus_err=1, x_rdata=0.
  - mem_req=0, state=IDLE.
- Minimum access = 3 cycles from req to ack (grant edge, ready edge, ack cycle). Back-to-back throughput = one access per 2 cycles.
- Streak counter:
  - DM grant while if_req=1: streak++, saturating.
  - Any IF grant: streak=0.
  - DM grant while if_req=0: streak=0.
- mem_ready seen in IDLE is ignored.
- Requester fields are sampled only at grant; later changes are ignored until ack.
- A req dropped before grant is never granted. A req dropped after grant still completes the memory access, and the ack is still issued.
- Reset mid-access: the transaction is abandoned, mem_req drops next cycle, and no ack is issued.
- mem_* outputs are held stable for the entire BUSY phase.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_IDLE=2'd0, ST_BUSY_IF=2'd1, ST_BUSY_DM=2'd2);
  - requester ID constants;
  - the 4-bit byte-enable width constant used by DM and the pipeline.
- One sub-module is natural: mem_port_grant, the combinational priority/starvation selector taking (if_elig, dm_elig, streak) and returning the grant ID.
- FSM, timer and registers stay in the top.

Test Plan:
- Single IF read, if_addr=0x10, mem_ready high 2 cycles after mem_req, mem_rdata=0x00500093 -> mem_req for 2 cycles; if_ack 1 cycle with if_rdata=0x00500093; stall_if high until the ack cycle.
- Simultaneous if_req and dm_req write (addr=0x40, wea=4'b0011, wdata=0xDEADBEEF), zero-wait memory -> DM granted first with mem_we=1, mem_wea=0011; IF granted next; acks 2 cycles apart.
- dm_req held continuously with if_req, MAX_DM_STREAK=4 -> 4 DM grants, then 1 IF grant, then DM resumes; streak reset observed.
- Memory never asserts ready, TIMEOUT=8 -> after 8 BUSY cycles, dm_ack=1 and bus_err=1 with dm_rdata=0; state IDLE; next request serviced normally.
- rst asserted in the 2nd BUSY_DM cycle -> next cycle mem_req=0, no dm_ack, all outputs at reset values; mem_ready arriving afterwards is ignored.
- Requester keeps req high through its ack cycle -> no regrant in the ack cycle; regrant occurs the following cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned WEA_W    = 4;
  localparam int unsigned STREAK_W = 4;
  localparam int unsigned TIMER_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } state_t;

  // Requester IDs as returned by the grant selector.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } gnt_t;

endpackage

// File: rtl/mem_port_grant.sv
// Combinational priority selector: DM wins unless IF has waited MAX_DM_STREAK grants.
module mem_port_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic                if_elig,
  input  logic                dm_elig,
  input  logic [STREAK_W-1:0] streak,
  output gnt_t                gnt
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_DM_STREAK);

  always_comb begin
    gnt = GNT_NONE;
    if (if_elig && dm_elig) begin
      gnt = (streak >= STREAK_LIMIT) ? GNT_IF : GNT_DM;
    end else if (dm_elig) begin
      gnt = GNT_DM;
    end else if (if_elig) begin
      gnt = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and MEM-stage data access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_ack,
  output logic [DW-1:0]    if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [WEA_W-1:0] dm_wea,
  input  logic [AW-1:0]    dm_addr,
  input  logic [DW-1:0]    dm_wdata,
  output logic             dm_ack,
  output logic [DW-1:0]    dm_rdata,
  output logic             bus_err,
  output logic             stall_if,
  output logic             stall_dm,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WEA_W-1:0] mem_wea,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ready
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [TIMER_W-1:0]  timer;
  logic                if_elig;
  logic                dm_elig;
  gnt_t                gnt;

  // A requester still holding req during its ack cycle must not be regranted.
  assign if_elig  = if_req & ~if_ack;
  assign dm_elig  = dm_req & ~dm_ack;
  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;

  mem_port_grant #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_grant (
    .if_elig(if_elig),
    .dm_elig(dm_elig),
    .streak (streak),
    .gnt    (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      streak    <= '0;
      timer     <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wea   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      bus_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          unique case (gnt)
            GNT_IF: begin
              state     <= ST_BUSY_IF;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_wea   <= '0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              timer     <= '0;
              streak    <= '0;
            end
            GNT_DM: begin
              state     <= ST_BUSY_DM;
              mem_req   <= 1'b1;
              mem_we    <= dm_we;
              mem_wea   <= dm_we ? dm_wea : '0;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              timer     <= '0;
              if (!if_req) begin
                streak <= '0;
              end else if (streak != '1) begin
                streak <= streak + 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_BUSY_IF, ST_BUSY_DM: begin
          if (mem_ready || (timer == TIMER_LAST)) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            bus_err <= ~mem_ready;
            if (state == ST_BUSY_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              dm_ack   <= 1'b1;
              dm_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a latency-programmable memory model.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_wea;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        bus_err;
  logic        stall_if;
  logic        stall_dm;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int   checks = 0;
  int   errors = 0;
  exp_t if_q[$];
  exp_t dm_q[$];

  // Memory model: ready after `lat` wait states, never when `hang`, forced by `ready_force`.
  logic [7:0]  lat = 8'd0;
  bit          hang = 1'b0;
  bit          ready_force = 1'b0;
  logic [7:0]  busy_cnt = 8'd0;
  logic [31:0] mem_arr [256];
  bit          wr_valid [256];

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'h0050_0093 : (32'hA000_0000 | {24'h0, a});
  endfunction

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return wr_valid[a] ? mem_arr[a] : init_word(a);
  endfunction

  assign mem_ready = (mem_req && !hang && (busy_cnt == lat)) || ready_force;
  assign mem_rdata = rd_word(mem_addr[7:0]);

  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_req === 1'b1 && !mem_ready) busy_cnt <= busy_cnt + 8'd1;
    else busy_cnt <= 8'd0;
    if (mem_req === 1'b1 && mem_ready && mem_we === 1'b1) begin
      w = rd_word(mem_addr[7:0]);
      for (int b = 0; b < 4; b++) if (mem_wea[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      mem_arr[mem_addr[7:0]]  <= w;
      wr_valid[mem_addr[7:0]] <= 1'b1;
    end
  end

  mem_port_arbiter #(
    .AW(32), .DW(32), .MAX_DM_STREAK(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wea(dm_wea), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .bus_err(bus_err), .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wea(mem_wea), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_dm, input int budget);
    int n = 0;
    while (((is_dm ? dm_ack : if_ack) !== 1'b1) && n < budget) begin
      step();
      n++;
    end
    chk(is_dm ? "dm_ack_within_budget" : "if_ack_within_budget", is_dm ? dm_ack : if_ack, 1);
  endtask

  // Scoreboard: every ack pops the oldest expectation for that requester.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (if_ack === 1'b1) begin
        checks++;
        assert (if_q.size() != 0) else begin
          errors++;
          $error("FAIL if_unexpected_ack: observed ack with rdata %0h expected no ack", if_rdata);
        end
        if (if_q.size() != 0) begin
          e = if_q.pop_front();
          chk("if_rdata", if_rdata, e.rdata);
          chk("if_bus_err", bus_err, e.err);
        end
      end
      if (dm_ack === 1'b1) begin
        checks++;
        assert (dm_q.size() != 0) else begin
          errors++;
          $error("FAIL dm_unexpected_ack: observed ack with rdata %0h expected no ack", dm_rdata);
        end
        if (dm_q.size() != 0) begin
          e = dm_q.pop_front();
          chk("dm_rdata", dm_rdata, e.rdata);
          chk("dm_bus_err", bus_err, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_wea = '0; dm_addr = '0; dm_wdata = '0;
    step(); step();
    chk("rst_mem_req", mem_req, 0);   chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wea", mem_wea, 0);   chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_ack", if_ack, 0);     chk("rst_dm_ack", dm_ack, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_dm_rdata", dm_rdata, 0);
    rst = 1'b0;
    step();

    // Single IF read, one wait state
    lat = 8'd1; if_addr = 32'h10; if_req = 1'b1;
    if_q.push_back('{32'h0050_0093, 1'b0});
    #1 chk("t1_stall_if_req", stall_if, 1);
    step();
    chk("t1_mem_req", mem_req, 1);  chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_we", mem_we, 0);    chk("t1_mem_wea", mem_wea, 0);
    step();
    chk("t1_mem_req_2nd", mem_req, 1); chk("t1_no_ack_yet", if_ack, 0);
    chk("t1_stall_if_busy", stall_if, 1);
    step();
    chk("t1_if_ack", if_ack, 1); chk("t1_stall_if_ack", stall_if, 0);
    chk("t1_mem_req_drop", mem_req, 0);
    if_req = 1'b0;
    step();
    chk("t1_ack_one_cycle", if_ack, 0);

    // Simultaneous IF read and DM write, zero-wait memory
    lat = 8'd0; if_addr = 32'h20; if_req = 1'b1;
    dm_req = 1'b1; dm_we = 1'b1; dm_wea = 4'b0011; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    dm_q.push_back('{32'h0, 1'b0});
    if_q.push_back('{32'hA000_0020, 1'b0});
    step();
    chk("t2_dm_first_we", mem_we, 1);     chk("t2_dm_first_wea", mem_wea, 4'b0011);
    chk("t2_dm_first_addr", mem_addr, 32'h40); chk("t2_dm_first_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("t2_dm_ack", dm_ack, 1); chk("t2_if_wait", if_ack, 0);
    dm_req = 1'b0; dm_we = 1'b0; dm_wea = '0;
    step();
    chk("t2_if_grant_addr", mem_addr, 32'h20); chk("t2_if_grant_we", mem_we, 0);
    chk("t2_if_grant_wea", mem_wea, 0);
    step();
    chk("t2_if_ack_2_later", if_ack, 1);
    if_req = 1'b0;
    step();

    // Starvation guard: IF drops req only in DM ack cycles, so both stay eligible at each grant
    if_addr = 32'h30; if_req = 1'b1; dm_addr = 32'h50; dm_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dm_q.push_back('{32'hA000_0050, 1'b0});
      step(); chk("t3_dm_grant", mem_addr, 32'h50);
      step(); chk("t3_dm_ack", dm_ack, 1); if_req = 1'b0;
      step(); chk("t3_idle_gap", mem_req, 0); if_req = 1'b1;
    end
    if_q.push_back('{32'hA000_0030, 1'b0});
    step(); chk("t3_if_grant_after_4", mem_addr, 32'h30); chk("t3_if_grant_we", mem_we, 0);
    dm_q.push_back('{32'hA000_0050, 1'b0});
    step(); chk("t3_if_ack", if_ack, 1);
    step(); chk("t3_dm_resume", mem_addr, 32'h50); chk("t3_dm_resume_req", mem_req, 1);
    step(); chk("t3_dm_resume_ack", dm_ack, 1); if_req = 1'b0;
    step(); chk("t3_idle_gap2", mem_req, 0); if_req = 1'b1;
    dm_q.push_back('{32'hA000_0050, 1'b0});
    step(); chk("t3_streak_reset", mem_addr, 32'h50);
    if_q.push_back('{32'hA000_0030, 1'b0});
    step(); chk("t3_dm_ack_last", dm_ack, 1); dm_req = 1'b0;
    step(); chk("t3_if_grant_last", mem_addr, 32'h30);
    step(); chk("t3_if_ack_last", if_ack, 1); if_req = 1'b0;
    step();

    // Timeout: memory never ready
    hang = 1'b1; dm_addr = 32'h60; dm_we = 1'b0; dm_req = 1'b1;
    dm_q.push_back('{32'h0, 1'b1});
    step(); chk("t4_grant", mem_req, 1); chk("t4_addr", mem_addr, 32'h60);
    for (int i = 1; i < 8; i++) begin
      step(); chk("t4_busy_no_ack", dm_ack, 0);
    end
    step();
    chk("t4_timeout_ack", dm_ack, 1); chk("t4_bus_err", bus_err, 1);
    chk("t4_mem_req_drop", mem_req, 0);
    dm_req = 1'b0; hang = 1'b0;
    step(); chk("t4_bus_err_pulse", bus_err, 0);
    lat = 8'd2; dm_addr = 32'h40; dm_req = 1'b1;
    dm_q.push_back('{32'hA000_BEEF, 1'b0});
    wait_ack(1'b1, 10);
    dm_req = 1'b0;
    step();

    // Reset in the second BUSY_DM cycle
    lat = 8'd3; dm_we = 1'b1; dm_wea = 4'hF; dm_addr = 32'h70; dm_wdata = 32'h1234_5678; dm_req = 1'b1;
    step(); chk("t5_grant", mem_req, 1);
    step(); rst = 1'b1; dm_req = 1'b0; dm_we = 1'b0; dm_wea = '0; dm_wdata = '0;
    step();
    chk("t5_mem_req", mem_req, 0);   chk("t5_mem_we", mem_we, 0);
    chk("t5_mem_wea", mem_wea, 0);   chk("t5_mem_addr", mem_addr, 0);
    chk("t5_mem_wdata", mem_wdata, 0); chk("t5_dm_ack", dm_ack, 0);
    chk("t5_dm_rdata", dm_rdata, 0); chk("t5_bus_err", bus_err, 0);
    rst = 1'b0; ready_force = 1'b1;
    step(); chk("t5_late_ready_no_ack", dm_ack, 0); chk("t5_late_ready_idle", mem_req, 0);
    ready_force = 1'b0;
    step(); chk("t5_still_no_ack", dm_ack, 0);
    lat = 8'd0; dm_addr = 32'h70; dm_req = 1'b1;
    dm_q.push_back('{32'hA000_0070, 1'b0});
    wait_ack(1'b1, 10);
    dm_req = 1'b0;
    step();

    // Requester holds req through its ack cycle
    lat = 8'd0; if_addr = 32'h10; if_req = 1'b1;
    if_q.push_back('{32'h0050_0093, 1'b0});
    if_q.push_back('{32'h0050_0093, 1'b0});
    step(); chk("t6_grant", mem_req, 1);
    step(); chk("t6_ack", if_ack, 1);
    step(); chk("t6_no_regrant", mem_req, 0); chk("t6_ack_low", if_ack, 0);
    step(); chk("t6_regrant", mem_req, 1);
    step(); chk("t6_ack2", if_ack, 1);
    if_req = 1'b0;
    step(); step();

    chk("if_queue_drained", if_q.size(), 0);
    chk("dm_queue_drained", dm_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
